// File: rtl/bin_bcd_seg_driver.sv
// rtl/bin_bcd_seg_driver.sv - iterative binary-to-BCD converter with multiplexed 7-segment scan
// Optional leading-zero blanking: define BCD_SEG_LZ_BLANK_EN.
module bin_bcd_seg_driver #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic                wovf_q, wovf_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;
  logic [3:0]          cur_digit;
  logic                blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Double-dabble step: add-3 on every digit >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    wovf_d    = wovf_q;
    cnt_d     = cnt_q;
    bcd_out_d = bcd_out_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: if (start) begin
        bin_d  = bin_in;
        bcd_d  = '0;
        wovf_d = 1'b0;
        cnt_d  = CW'(WIDTH);
      end
      S_SHIFT: begin
        bcd_d  = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_d  = bin_q << 1;
        wovf_d = wovf_q | adj[4*DIGITS-1];
        cnt_d  = cnt_q - CW'(1);
        // Latch on the final shift so the result is visible in the DONE cycle.
        if (cnt_q == CW'(1)) begin
          bcd_out_d = bcd_d;
          ovf_d     = wovf_d;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      wovf_q     <= 1'b0;
      cnt_q      <= '0;
      bcd_out_q  <= '0;
      ovf_q      <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      wovf_q     <= wovf_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      ovf_q      <= ovf_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign cur_digit = bcd_out_q[4*scan_idx_q +: 4];

`ifdef BCD_SEG_LZ_BLANK_EN
  logic upper_zero;
  always_comb begin
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(scan_idx_q) && bcd_out_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
    blank = (scan_idx_q != '0) && upper_zero;
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    case (cur_digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    if (blank) seg = 7'b0000000;
  end

  assign an      = DIGITS'(1) << scan_idx_q;
  assign bcd_out = bcd_out_q;
  assign ovf     = ovf_q;

endmodule
